// File: rtl/onehot_pulse_decoder.sv
// onehot_pulse_decoder
//   Sequential 3-to-8 decoder. It accepts a 3-bit index over a valid/ready
//   handshake and drives the matching one-hot line for PULSE_LEN cycles.
//   It then forces GAP_LEN all-zero cycles before it accepts the next index.
//
// Parameters
//   PULSE_LEN   cycles each one-hot pulse is held (1..255)
//   GAP_LEN     idle cycles after each pulse (0..255)
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   din         encoded index 0..7
//   din_valid   din is valid this cycle
//   din_ready   block can accept (IDLE and not in reset)
//   dout        registered one-hot output, zero when not driving
//   dout_valid  registered, high exactly while dout is non-zero
//   done        registered single-cycle pulse on the last drive cycle
//
// state | meaning
// IDLE  | waiting for din_valid, din_ready high
// DRIVE | one-hot line held high, cnt counts down remaining drive cycles
// GAP   | forced all-zero output, cnt counts down remaining gap cycles
module onehot_pulse_decoder #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(GAP_LEN - 1);
  localparam bit         HAS_GAP    = (GAP_LEN > 0);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [2:0] code, code_nxt;
  logic [7:0] dout_nxt;
  logic       drive_nxt;
  logic       done_nxt;

  assign din_ready = (state == IDLE) && !rst;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    code_nxt  = code;
    case (state)
      IDLE: begin
        if (din_valid) begin
          state_nxt = DRIVE;
          cnt_nxt   = PULSE_LOAD;
          code_nxt  = din;
        end
      end
      DRIVE: begin
        if (cnt == 8'd0) begin
          if (HAS_GAP) begin
            state_nxt = GAP;
            cnt_nxt   = GAP_LOAD;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
          end
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      GAP: begin
        if (cnt == 8'd0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase

    // Outputs are computed from the next state so that the registered
    // versions line up with the cycle the state machine is in.
    drive_nxt = (state_nxt == DRIVE);
    dout_nxt  = drive_nxt ? (8'd1 << code_nxt) : 8'd0;
    done_nxt  = drive_nxt && (cnt_nxt == 8'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      code       <= 3'd0;
      dout       <= 8'h00;
      dout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      code       <= code_nxt;
      dout       <= dout_nxt;
      dout_valid <= drive_nxt;
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Directed testbench for onehot_pulse_decoder. u_dut uses the default
// configuration (PULSE_LEN=4, GAP_LEN=1). u_min uses the minimum
// configuration (PULSE_LEN=1, GAP_LEN=0).
module tb_onehot_pulse_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] din = 3'd0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       done;

  logic [2:0] din2 = 3'd0;
  logic       din_valid2 = 1'b0;
  logic       din_ready2;
  logic [7:0] dout2;
  logic       dout_valid2;
  logic       done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onehot_pulse_decoder u_dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .done       (done)
  );

  onehot_pulse_decoder #(.PULSE_LEN(1), .GAP_LEN(0)) u_min (
    .clk        (clk),
    .rst        (rst),
    .din        (din2),
    .din_valid  (din_valid2),
    .din_ready  (din_ready2),
    .dout       (dout2),
    .dout_valid (dout_valid2),
    .done       (done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks every output of the default instance against expected values.
  task automatic look(input string tag, input logic [7:0] e_dout, input logic e_done,
                      input logic e_ready);
    chk({tag, ".dout"}, 32'(dout), 32'(e_dout));
    chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(e_dout != 8'h00));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
    chk({tag, ".din_ready"}, 32'(din_ready), 32'(e_ready));
  endtask

  task automatic look_min(input string tag, input logic [7:0] e_dout, input logic e_done,
                          input logic e_ready);
    chk({tag, ".dout"}, 32'(dout2), 32'(e_dout));
    chk({tag, ".dout_valid"}, 32'(dout_valid2), 32'(e_dout != 8'h00));
    chk({tag, ".done"}, 32'(done2), 32'(e_done));
    chk({tag, ".din_ready"}, 32'(din_ready2), 32'(e_ready));
  endtask

  // Advance one cycle and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] oh;

    // Reset asserted before any clock edge.
    #3 rst = 1'b1;
    #1;
    look("reset_async", 8'h00, 1'b0, 1'b0);
    step();
    step();
    look("reset_held", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("reset_release.din_ready", 32'(din_ready), 32'd1);
    chk("reset_release_min.din_ready", 32'(din_ready2), 32'd1);

    // Single decode of code 5.
    din = 3'd5; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    look("single_t1", 8'h20, 1'b0, 1'b0);
    step(); look("single_t2", 8'h20, 1'b0, 1'b0);
    step(); look("single_t3", 8'h20, 1'b0, 1'b0);
    step(); look("single_t4", 8'h20, 1'b1, 1'b0);
    step(); look("single_t5", 8'h00, 1'b0, 1'b0);
    step(); look("single_t6", 8'h00, 1'b0, 1'b1);

    // Full sweep with din_valid held high. Stray codes appear while busy.
    din_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      din = 3'(k);
      oh = 8'h01 << k;
      chk($sformatf("sweep%0d_accept.din_ready", k), 32'(din_ready), 32'd1);
      step();
      for (int j = 1; j <= 5; j++) begin
        din = 3'(k + 3);
        look($sformatf("sweep%0d_c%0d", k, j), (j <= 4) ? oh : 8'h00, j == 4, 1'b0);
        step();
      end
    end
    din_valid = 1'b0;
    look("sweep_end", 8'h00, 1'b0, 1'b1);

    // Busy-ignore: code 7 is offered during the drive of code 2.
    din = 3'd2; din_valid = 1'b1;
    step();
    din = 3'd7;
    look("busy_t1", 8'h04, 1'b0, 1'b0);
    step(); look("busy_t2", 8'h04, 1'b0, 1'b0);
    step(); look("busy_t3", 8'h04, 1'b0, 1'b0);
    step(); look("busy_t4", 8'h04, 1'b1, 1'b0);
    step(); look("busy_t5", 8'h00, 1'b0, 1'b0);
    step(); look("busy_t6", 8'h00, 1'b0, 1'b1);
    step();
    din_valid = 1'b0;
    look("busy_seven_t1", 8'h80, 1'b0, 1'b0);
    step(); step(); step();
    look("busy_seven_t4", 8'h80, 1'b1, 1'b0);
    step(); step();
    look("busy_seven_idle", 8'h00, 1'b0, 1'b1);

    // Minimum configuration: codes 3 then 6 with continuous valid.
    din2 = 3'd3; din_valid2 = 1'b1;
    step();
    din2 = 3'd6;
    look_min("min_c3", 8'h08, 1'b1, 1'b0);
    step(); look_min("min_idle", 8'h00, 1'b0, 1'b1);
    step();
    din_valid2 = 1'b0;
    look_min("min_c6", 8'h40, 1'b1, 1'b0);
    step(); look_min("min_end", 8'h00, 1'b0, 1'b1);

    // Async reset in the second drive cycle of code 4.
    din = 3'd4; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    look("rstmid_t1", 8'h10, 1'b0, 1'b0);
    step();
    look("rstmid_t2", 8'h10, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    look("rstmid_async", 8'h00, 1'b0, 1'b0);
    step();
    look("rstmid_held", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    din = 3'd1; din_valid = 1'b1;
    #1;
    chk("rstmid_release.din_ready", 32'(din_ready), 32'd1);
    step();
    din_valid = 1'b0;
    look("after_rst_t1", 8'h02, 1'b0, 1'b0);
    step(); look("after_rst_t2", 8'h02, 1'b0, 1'b0);
    step(); look("after_rst_t3", 8'h02, 1'b0, 1'b0);
    step(); look("after_rst_t4", 8'h02, 1'b1, 1'b0);
    step(); look("after_rst_t5", 8'h00, 1'b0, 1'b0);
    step(); look("after_rst_t6", 8'h00, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_pulse_decoder.md
# onehot_pulse_decoder

Sequential 3-to-8 decoder, the inverse of the team's 8-to-3 one-hot encoder. A 3-bit index arrives over a valid/ready handshake. The block drives the matching one-hot line on an 8-bit output for a programmable number of cycles, then holds a programmable idle gap. It sits between control logic that produces encoded select codes and downstream strobe/select consumers that need clean, timed one-hot pulses.

## Interface
- PULSE_LEN, 4, cycles each one-hot pulse is held high; legal range 1..255
- GAP_LEN, 1, forced all-zero cycles after each pulse before the next accept; legal range 0..255
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- din  input  3  encoded index 0..7; all 8 values legal
- din_valid  input  1  din is valid this cycle
- din_ready  output  1  block can accept; equals (state == IDLE) && !rst
- dout  output  8  registered one-hot output, bit din set; all-zero when not driving
- dout_valid  output  1  registered; high exactly while dout is non-zero
- done  output  1  registered single-cycle pulse on the last DRIVE cycle of each pulse

## Operation
- States: IDLE, DRIVE, GAP; 8-bit down-counter cnt.
- IDLE:
  - din_ready = 1.
  - Accept when din_valid && din_ready: latch din, load cnt = PULSE_LEN-1, go to DRIVE.
  - dout = 0, dout_valid = 0.
- DRIVE:
  - dout = 8'b1 << latched code, dout_valid = 1, din_ready = 0; din and din_valid are ignored.
  - cnt decrements each cycle. When cnt == 0, done = 1 that cycle.
  - Next state after cnt == 0: GAP with cnt = GAP_LEN-1 if GAP_LEN > 0, else IDLE.
- GAP:
  - dout = 0, dout_valid = 0, din_ready = 0.
  - When cnt == 0, go to IDLE.
- Decode rule: dout[i] = (code == i). dout is never multi-hot and never changes mid-pulse.
- Reset, asserted at any time including mid-DRIVE or mid-GAP:
  - Immediately, asynchronously: state = IDLE, cnt = 0, latched code = 0, dout = 8'h00, dout_valid = 0, done = 0.
  - din_ready = 0 while rst is high.
- Reset values of all outputs: dout 8'h00, dout_valid 0, done 0, din_ready 0 (rises to 1 combinationally when rst falls).
- A din_valid held high in IDLE is accepted on the first rising edge with rst low.

## Timing
- Accept edge is T (din_valid && din_ready sampled high).
- dout and dout_valid rise at T+1 and stay high for exactly PULSE_LEN cycles, T+1..T+PULSE_LEN.
- done is high only in cycle T+PULSE_LEN.
- With GAP_LEN > 0, GAP occupies T+PULSE_LEN+1..T+PULSE_LEN+GAP_LEN.
- din_ready returns to 1 at T+PULSE_LEN+GAP_LEN+1.
- Minimum accept-to-accept period is PULSE_LEN+GAP_LEN+1 cycles. For PULSE_LEN=1, GAP_LEN=0 this is 2 cycles.
- dout_valid == |dout holds on every cycle.
- All outputs except din_ready are registers with no combinational path from din or din_valid.

## Test plan
- Reset then idle: assert rst mid-cycle, no clock edge -> dout 8'h00, dout_valid 0, done 0, din_ready 0. Release -> din_ready 1.
- Single decode, defaults (PULSE_LEN=4, GAP_LEN=1): din=5 accepted at T -> dout 8'b0010_0000 for T+1..T+4, done at T+4, dout 0 at T+5, din_ready 1 at T+6.
- Full sweep: din 0..7 back-to-back with din_valid held high -> dout walks 8'h01, 8'h02, …, 8'h80. Each pulse is 4 cycles, accepts are 6 cycles apart, and no stray codes are captured while din_ready = 0.
- Busy-ignore: during DRIVE of code 2, present din=7, din_valid=1 -> dout stays 8'h04. Code 7 is accepted only once din_ready = 1, and then dout = 8'h80.
- Minimum config PULSE_LEN=1, GAP_LEN=0: continuous valid with codes 3,6 -> dout 8'h08 for 1 cycle, 0 for 1 cycle, then 8'h40; done coincides with each non-zero dout cycle.
- Async reset mid-pulse: rst asserted in the 2nd DRIVE cycle of code 4 -> dout 8'h00 and dout_valid 0 immediately, before the next edge, with no done pulse. After release, a new accept of din=1 gives 8'h02 with full PULSE_LEN.
